// File: rtl/priority_cases.sv
`default_nettype none
// ============================================================================
//  Module   : priority_cases
//  Purpose  : Registered N-bit priority circuit. The most-significant set bit
//             of d is presented one-hot on q, one clock after capture.
//  Revision : 1.0 - initial release
//
//  Parameters
//    WIDTH  - request/grant vector width, 1..32 (default 4)
//    IDX_W  - index width, max(1, clog2(WIDTH)); derived, not overridable
//
//  Ports
//    clk    in   1      rising-edge clock
//    reset  in   1      synchronous active-high reset (overrides en)
//    en     in   1      capture enable; outputs hold while low
//    d      in   WIDTH  request vector, bit WIDTH-1 has highest priority
//    q      out  WIDTH  registered one-hot grant, zero when no request
//    valid  out  1      registered "captured d was non-zero"
//    idx    out  IDX_W  registered binary position of the grant
//                       (present only with PRIOR_CASES_INDEX_EN)
//
//  Build option
//    PRIOR_CASES_INDEX_EN - when defined, adds the idx port and its register.
// ============================================================================
module priority_cases #(
    parameter  int WIDTH = 4,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
`ifdef PRIOR_CASES_INDEX_EN
    output logic [IDX_W-1:0] idx,
`endif
    output logic             valid
);

    logic [WIDTH-1:0] w_grant;
    logic [WIDTH-1:0] r_q;
    logic             r_valid;

    // Scan from LSB upward so the highest set bit is the last one written;
    // clearing before each write keeps the result strictly one-hot.
    always_comb begin
        w_grant = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (d[i]) begin
                w_grant    = '0;
                w_grant[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q     <= '0;
            r_valid <= 1'b0;
        end else if (en) begin
            r_q     <= w_grant;
            r_valid <= |d;
        end
    end

    assign q     = r_q;
    assign valid = r_valid;

`ifdef PRIOR_CASES_INDEX_EN
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] r_idx;

    // Same upward scan as the grant; stays 0 when d is all zero.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (d[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= '0;
        end else if (en) begin
            r_idx <= w_idx;
        end
    end

    assign idx = r_idx;
`endif

endmodule
`default_nettype wire

// File: tb/tb_priority_cases.sv
`default_nettype none
// ============================================================================
//  Module   : tb_priority_cases
//  Purpose  : Directed self-checking bench for priority_cases. Exercises a
//             4-bit instance and an 8-bit instance; idx is checked when the
//             bench is built with PRIOR_CASES_INDEX_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_priority_cases;

    logic       clk;
    logic       reset;
    logic       en;
    logic [3:0] d4;
    logic [3:0] q4;
    logic       valid4;
    logic [7:0] d8;
    logic [7:0] q8;
    logic       valid8;
`ifdef PRIOR_CASES_INDEX_EN
    logic [1:0] idx4;
    logic [2:0] idx8;
`endif

    int n_checks = 0;
    int n_errors = 0;

    priority_cases #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .d     (d4),
        .q     (q4),
`ifdef PRIOR_CASES_INDEX_EN
        .idx   (idx4),
`endif
        .valid (valid4)
    );

    priority_cases #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .d     (d8),
        .q     (q8),
`ifdef PRIOR_CASES_INDEX_EN
        .idx   (idx8),
`endif
        .valid (valid8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hand-computed one-hot MSB for every 4-bit value 0..15.
    logic [3:0] exp_tab [16] = '{4'h0, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h4, 4'h4,
                                 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8};
    // Test 2 vectors and expectations.
    logic [3:0] seq_d [6] = '{4'b1111, 4'b0000, 4'b1100, 4'b0011, 4'b1010, 4'b1111};
    logic [3:0] seq_q [6] = '{4'b1000, 4'b0000, 4'b1000, 4'b0010, 4'b1000, 4'b1000};
    logic       seq_v [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [1:0] seq_i [6] = '{2'd3, 2'd0, 2'd3, 2'd1, 2'd3, 2'd3};

    initial begin
        // 1. Reset with requests present
        reset = 1'b1; en = 1'b1; d4 = 4'b1111; d8 = 8'h00;
        tick(); tick();
        chk("reset_q", 32'(q4), 32'h0);
        chk("reset_valid", 32'(valid4), 32'h0);
`ifdef PRIOR_CASES_INDEX_EN
        chk("reset_idx", 32'(idx4), 32'h0);
`endif
        chk("reset_q8", 32'(q8), 32'h0);
        reset = 1'b0;
        tick();
        chk("post_reset_q", 32'(q4), 32'h8);
        chk("post_reset_valid", 32'(valid4), 32'h1);
`ifdef PRIOR_CASES_INDEX_EN
        chk("post_reset_idx", 32'(idx4), 32'h3);
`endif

        // 2. Streaming sequence, one value per clock
        for (int i = 0; i < 6; i++) begin
            d4 = seq_d[i];
            tick();
            chk($sformatf("seq%0d_q", i), 32'(q4), 32'(seq_q[i]));
            chk($sformatf("seq%0d_valid", i), 32'(valid4), 32'(seq_v[i]));
`ifdef PRIOR_CASES_INDEX_EN
            chk($sformatf("seq%0d_idx", i), 32'(idx4), 32'(seq_i[i]));
`endif
        end

        // 3. Exhaustive 4-bit sweep
        for (int v = 0; v < 16; v++) begin
            d4 = 4'(v);
            tick();
            chk($sformatf("sweep%0d_q", v), 32'(q4), 32'(exp_tab[v]));
            chk($sformatf("sweep%0d_onehot", v), 32'($countones(q4) <= 1), 32'h1);
        end

        // 4. Hold while en is low
        d4 = 4'b0011;
        tick();
        chk("hold_capture_q", 32'(q4), 32'h2);
        en = 1'b0; d4 = 4'b1000;
        tick(); tick(); tick();
        chk("hold_q", 32'(q4), 32'h2);
        chk("hold_valid", 32'(valid4), 32'h1);
        en = 1'b1;
        tick();
        chk("hold_release_q", 32'(q4), 32'h8);

        // 5. Reset wins over en on the same edge
        d4 = 4'b0100; reset = 1'b1;
        tick();
        chk("rst_prio_q", 32'(q4), 32'h0);
        chk("rst_prio_valid", 32'(valid4), 32'h0);
        reset = 1'b0;

        // 6. 8-bit instance
        d8 = 8'b0001_0110;
        tick();
        chk("w8_q", 32'(q8), 32'h10);
        chk("w8_valid", 32'(valid8), 32'h1);
`ifdef PRIOR_CASES_INDEX_EN
        chk("w8_idx", 32'(idx8), 32'h4);
`endif
        d8 = 8'h80;
        tick();
        chk("w8_top_q", 32'(q8), 32'h80);
`ifdef PRIOR_CASES_INDEX_EN
        chk("w8_top_idx", 32'(idx8), 32'h7);
`endif
        d8 = 8'h01;
        tick();
        chk("w8_bot_q", 32'(q8), 32'h01);
        d8 = 8'h00;
        tick();
        chk("w8_zero_q", 32'(q8), 32'h0);
        chk("w8_zero_valid", 32'(valid8), 32'h0);
`ifdef PRIOR_CASES_INDEX_EN
        chk("w8_zero_idx", 32'(idx8), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/priority_cases.md
Name: priority_cases

Overview:
- Registered N-bit priority circuit: selects the most-significant asserted bit of input d and presents it as a one-hot vector q.
- Default width is 4 bits.
- Used as a request-arbitration / leading-one detection primitive in datapath and control logic.
- Output is registered with one clock of latency. An optional binary index output can be compiled in.

Parameters:
- WIDTH, 4, input/output vector width; legal range 1..32.
- IDX_W, max(1, clog2(WIDTH)), width of index output; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  capture enable; the output registers update only when en=1.
- d  input  WIDTH  request vector; bit WIDTH-1 has highest priority.
- q  output  WIDTH  registered one-hot grant; all zero when no request.
- valid  output  1  registered; 1 when the captured d had at least one bit set.
- idx  output  IDX_W  registered binary position of the granted bit. Present only with PRIOR_CASES_INDEX_EN.

Behaviour:
- Combinational priority function p(d):
  - If d[WIDTH-1]=1, then p = 1<<(WIDTH-1).
  - Otherwise, if d[WIDTH-2]=1, then p = 1<<(WIDTH-2). This continues down to bit 0.
  - If d=0, then p=0.
  - For WIDTH=4: 1??? gives 1000, 01?? gives 0100, 001? gives 0010, 0001 gives 0001, 0000 gives 0000.
- Lower-priority bits are don't-care once a higher bit is set.
- q is always one-hot or all-zero; it never has two bits set.
- Rising edge of clk with reset=1: q<=0, valid<=0, idx<=0. Reset overrides en.
- Rising edge with reset=0 and en=1: q<=p(d), valid<=|d, idx<=position of the MSB set in d (0 if d=0).
- Rising edge with reset=0 and en=0: all outputs hold their values.
- Latency: q, valid and idx reflect the d sampled on the preceding enabled rising edge (1 cycle).
- Throughput is one result per cycle; there is no handshake or backpressure.
- Reset asserted mid-stream clears outputs on that edge. The first enabled edge after reset release produces a fresh result.
- X or Z on d is not a supported condition and need not be handled.
- Outputs after power-up are undefined until the first reset edge.
- WIDTH=1: q=d registered, valid=d, idx always 0.

Optional Feature:
- Macro: PRIOR_CASES_INDEX_EN.
- Defined:
  - Port idx (IDX_W bits) exists.
  - It is registered alongside q under the same reset/en rules.
  - Encoding is the binary index of q's set bit; it is 0 when valid=0.
- Undefined:
  - Port idx and its registers are absent.
  - q and valid behave identically in both builds.

Test Plan:
1. Reset: hold reset=1 for 2 clocks with d=1111, en=1 -> q=0000, valid=0, idx=0. Then release reset -> next edge gives q=1000, valid=1, idx=3.
2. Sequence with en=1, one value per clock: d=1111, 0000, 1100, 0011, 1010, 1111 -> one cycle later q=1000, 0000, 1000, 0010, 1000, 1000. valid=1,0,1,1,1,1. idx=3,0,3,1,3,3.
3. Exhaustive: all 16 values of d (WIDTH=4) -> q equals the one-hot MSB of d (e.g. 0101 gives 0100, 0001 gives 0001). q is never multi-hot.
4. Hold: capture d=0011 (q=0010), then drop en=0 and drive d=1000 for 3 clocks -> q stays 0010. Raising en gives q=1000 one edge later.
5. Reset priority: en=1, d=0100 and reset=1 on the same edge -> q=0000, valid=0.
6. Build with WIDTH=8 and PRIOR_CASES_INDEX_EN defined: d=00010110 -> q=00010000, idx=4. d=00000000 -> q=0, valid=0, idx=0.
